// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
//   Shared types for the NTT address sequencer.
//   stateT : sequencer control state (IDLE waiting for start, RUN emitting
//            butterfly pairs).
//   modeT  : transform flavour captured at start (FWD = Cooley-Tukey with
//            shrinking butterfly span, INV = Gentleman-Sande with growing span).
// ---------------------------------------------------------------------------
package ntt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  typedef enum logic {
    FWD = 1'b0,
    INV = 1'b1
  } modeT;

endpackage

// File: rtl/ntt_addr_seq.sv
// ---------------------------------------------------------------------------
// ntt_addr_seq
//   Generates the complete butterfly address stream for an in-place NTT of
//   length N = 2^LOG_N. For every stage it walks group (outer) and k (inner)
//   and presents one pair per valid/ready handshake:
//     addr_a  = group*2*half + k
//     addr_b  = addr_a + half
//     tw_addr = N/(2*half) + group
//   Forward mode uses half = N >> (stage+1), inverse uses half = 1 << stage.
//   All products are powers of two, so everything is shifts plus counters.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (wins over start)
//   start    in   launch a transform when idle
//   inverse  in   mode captured together with start (0 fwd, 1 inv)
//   ready    in   consumer accepts the presented pair this cycle
//   valid    out  addr_a/addr_b/tw_addr/stage hold a pair
//   addr_a   out  lower butterfly address
//   addr_b   out  upper butterfly address
//   tw_addr  out  twiddle ROM index
//   stage    out  current stage 0..LOG_N-1
//   busy     out  transform in progress
//   done     out  one-cycle pulse after the final pair is accepted
// ---------------------------------------------------------------------------
module ntt_addr_seq
  import ntt_pkg::*;
#(
  parameter int LOG_N = 8,
  parameter int SW    = $clog2(LOG_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inverse,
  input  logic             ready,
  output logic             valid,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic [SW-1:0]    stage,
  output logic             busy,
  output logic             done
);

  localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG_N - 1);
  localparam logic [SW-1:0]    STAGE_ONE  = SW'(1);
  localparam logic [LOG_N-1:0] ONE        = LOG_N'(1);

  stateT            state;
  modeT             modeReg;
  logic [LOG_N-1:0] groupCnt;
  logic [LOG_N-1:0] kCnt;

  // log2(half) for a given mode and stage.
  function automatic logic [SW-1:0] logHalfOf(input modeT m, input logic [SW-1:0] s);
    return (m == FWD) ? (LAST_STAGE - s) : s;
  endfunction

  function automatic logic [LOG_N-1:0] halfOf(input modeT m, input logic [SW-1:0] s);
    return ONE << logHalfOf(m, s);
  endfunction

  // Groups per stage: N/(2*half) = 2^(LOG_N-1-log2(half)). This is also the
  // twiddle base index for the stage.
  function automatic logic [LOG_N-1:0] groupsOf(input modeT m, input logic [SW-1:0] s);
    return ONE << (LAST_STAGE - logHalfOf(m, s));
  endfunction

  // ------------------------------------------------------------------------
  // Next-pair computation. Counters and addresses for the pair that follows
  // the one currently presented; only committed on a handshake.
  // ------------------------------------------------------------------------
  logic [LOG_N-1:0] curHalf;
  logic [LOG_N-1:0] curGroups;
  logic             lastK;
  logic             lastGroup;
  logic             lastStage;
  logic             finalPair;
  logic [SW-1:0]    nxtStage;
  logic [LOG_N-1:0] nxtGroup;
  logic [LOG_N-1:0] nxtK;
  logic [SW-1:0]    nxtLogHalf;
  logic [LOG_N-1:0] nxtHalf;
  logic [LOG_N-1:0] nxtGroups;
  logic [LOG_N-1:0] nxtA;
  modeT             startMode;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which keeps this purely combinational (no latch).
  always_comb begin
    curHalf    = halfOf(modeReg, stage);
    curGroups  = groupsOf(modeReg, stage);
    lastK      = (kCnt == curHalf - ONE);
    lastGroup  = (groupCnt == curGroups - ONE);
    lastStage  = (stage == LAST_STAGE);
    finalPair  = lastK && lastGroup && lastStage;

    nxtStage   = stage;
    nxtGroup   = groupCnt;
    nxtK       = kCnt + ONE;
    if (lastK) begin
      nxtK     = '0;
      nxtGroup = groupCnt + ONE;
      if (lastGroup) begin
        // Stage boundary: the first pair of the next stage follows directly,
        // so there is no idle cycle between stages.
        nxtGroup = '0;
        nxtStage = stage + STAGE_ONE;
      end
    end

    // group*2*half is a left shift by log2(half)+1; done as two shifts so the
    // amount never needs more than SW bits.
    nxtLogHalf = logHalfOf(modeReg, nxtStage);
    nxtHalf    = ONE << nxtLogHalf;
    nxtGroups  = groupsOf(modeReg, nxtStage);
    nxtA       = ((nxtGroup << nxtLogHalf) << 1) + nxtK;

    startMode  = inverse ? INV : FWD;
  end

  // ------------------------------------------------------------------------
  // Control FSM with registered outputs. Outputs are forced to zero whenever
  // no pair is presented, so the address bus is quiet between transforms.
  // ------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      modeReg  <= FWD;
      groupCnt <= '0;
      kCnt     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      tw_addr  <= '0;
      stage    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Mode is latched here and held for the whole transform, so
            // later changes on inverse have no effect.
            state    <= RUN;
            modeReg  <= startMode;
            groupCnt <= '0;
            kCnt     <= '0;
            valid    <= 1'b1;
            busy     <= 1'b1;
            stage    <= '0;
            addr_a   <= '0;
            addr_b   <= halfOf(startMode, '0);
            tw_addr  <= groupsOf(startMode, '0);
          end
        end

        RUN: begin
          // start is deliberately not examined while running.
          if (valid && ready) begin
            if (finalPair) begin
              state    <= IDLE;
              groupCnt <= '0;
              kCnt     <= '0;
              valid    <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              stage    <= '0;
              addr_a   <= '0;
              addr_b   <= '0;
              tw_addr  <= '0;
            end else begin
              groupCnt <= nxtGroup;
              kCnt     <= nxtK;
              stage    <= nxtStage;
              addr_a   <= nxtA;
              addr_b   <= nxtA + nxtHalf;
              tw_addr  <= nxtGroups + nxtGroup;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_ntt_addr_seq
//   Two sequencer instances (LOG_N=3 and LOG_N=8) share one set of inputs;
//   sel8 picks which one is being checked. Expected pair streams come from a
//   nested-loop model of the transform, plus a literal table for the small
//   forward case.
// ---------------------------------------------------------------------------
module tb_ntt_addr_seq;

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
  } pairT;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic inverse;
  logic ready;

  logic       valid3, busy3, done3;
  logic [2:0] addrA3, addrB3, tw3;
  logic [1:0] stage3;

  logic       valid8, busy8, done8;
  logic [7:0] addrA8, addrB8, tw8;
  logic [2:0] stage8;

  always #5 clk = ~clk;

  ntt_addr_seq #(.LOG_N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse), .ready(ready),
    .valid(valid3), .addr_a(addrA3), .addr_b(addrB3), .tw_addr(tw3),
    .stage(stage3), .busy(busy3), .done(done3)
  );

  ntt_addr_seq #(.LOG_N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse), .ready(ready),
    .valid(valid8), .addr_a(addrA8), .addr_b(addrB8), .tw_addr(tw8),
    .stage(stage8), .busy(busy8), .done(done8)
  );

  // Selected-instance view.
  logic sel8;
  logic oValid, oBusy, oDone;
  int   oA, oB, oTw, oSt;

  always_comb begin
    if (sel8) begin
      oValid = valid8; oBusy = busy8; oDone = done8;
      oA = int'(addrA8); oB = int'(addrB8); oTw = int'(tw8); oSt = int'(stage8);
    end else begin
      oValid = valid3; oBusy = busy3; oDone = done3;
      oA = int'(addrA3); oB = int'(addrB3); oTw = int'(tw3); oSt = int'(stage3);
    end
  end

  // Independent handshake counter on the large instance.
  int hs8 = 0;
  always @(posedge clk) begin
    if (valid8 && ready) hs8 <= hs8 + 1;
  end

  int   checks = 0;
  int   errors = 0;
  pairT expQ[$];
  int   idx;

  int fwdTab[12][3] = '{
    '{0, 4, 1}, '{1, 5, 1}, '{2, 6, 1}, '{3, 7, 1},
    '{0, 2, 2}, '{1, 3, 2}, '{4, 6, 3}, '{5, 7, 3},
    '{0, 1, 4}, '{2, 3, 5}, '{4, 5, 6}, '{6, 7, 7}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain loops over stage/group/k with ordinary arithmetic.
  function automatic void buildSeq(input int logN, input bit inv);
    int n;
    int half;
    expQ.delete();
    n = 1 << logN;
    for (int s = 0; s < logN; s++) begin
      half = inv ? (1 << s) : (n >> (s + 1));
      for (int g = 0; g < n / (2 * half); g++) begin
        for (int k = 0; k < half; k++) begin
          expQ.push_back('{a: g * 2 * half + k, b: g * 2 * half + k + half,
                           tw: n / (2 * half) + g, st: s});
        end
      end
    end
  endfunction

  task automatic applyReset();
    rst = 1'b1; start = 1'b0; inverse = 1'b0; ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic startXfer(input bit inv, input bit keepStart);
    start = 1'b1;
    inverse = inv;
    tick();
    if (!keepStart) start = 1'b0;
    idx = 0;
  endtask

  // Follow the stream until `upto` pairs have been accepted. Every cycle the
  // presented pair must equal expQ[idx]; during stalls idx is unchanged, so
  // this also demands stable outputs.
  task automatic follow(input int upto, input int readyPct, input bit noise);
    int budget;
    bit rdy;
    bit wasValid;
    budget = 0;
    while (idx < upto) begin
      checks++;
      if (oValid !== 1'b1 || oBusy !== 1'b1 || oDone !== 1'b0 ||
          oA != expQ[idx].a || oB != expQ[idx].b ||
          oTw != expQ[idx].tw || oSt != expQ[idx].st) begin
        errors++;
        $display("FAIL pair[%0d] got v=%0b busy=%0b done=%0b (%0d,%0d,%0d) st=%0d expected v=1 busy=1 done=0 (%0d,%0d,%0d) st=%0d",
                 idx, oValid, oBusy, oDone, oA, oB, oTw, oSt,
                 expQ[idx].a, expQ[idx].b, expQ[idx].tw, expQ[idx].st);
      end
      rdy = ($urandom_range(99) < readyPct);
      ready = rdy;
      if (noise) begin
        start = 1'($urandom_range(1));
        inverse = 1'($urandom_range(1));
      end
      wasValid = oValid;
      tick();
      if (rdy && wasValid) idx++;
      budget++;
      if (budget > 20000) begin
        checks++;
        errors++;
        $display("FAIL follow_timeout got idx=%0d expected idx=%0d", idx, upto);
        break;
      end
    end
    if (noise) begin
      start = 1'b0;
      inverse = 1'b0;
    end
  endtask

  task automatic checkDone(input string name);
    checks++;
    if (oDone !== 1'b1 || oValid !== 1'b0 || oBusy !== 1'b0 ||
        oA != 0 || oB != 0 || oTw != 0 || oSt != 0) begin
      errors++;
      $display("FAIL %s_done got done=%0b v=%0b busy=%0b (%0d,%0d,%0d,%0d) expected done=1 v=0 busy=0 zeros",
               name, oDone, oValid, oBusy, oA, oB, oTw, oSt);
    end
  endtask

  task automatic checkQuiet(input string name);
    checks++;
    if (oDone !== 1'b0 || oValid !== 1'b0 || oBusy !== 1'b0 ||
        oA != 0 || oB != 0 || oTw != 0 || oSt != 0) begin
      errors++;
      $display("FAIL %s_quiet got done=%0b v=%0b busy=%0b (%0d,%0d,%0d,%0d) expected all 0",
               name, oDone, oValid, oBusy, oA, oB, oTw, oSt);
    end
  endtask

  task automatic test_reset();
    applyReset();
    sel8 = 1'b0; checkQuiet("reset3");
    sel8 = 1'b1; checkQuiet("reset8");
    // rst wins over start in the same cycle.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    sel8 = 1'b0; checkQuiet("rst_vs_start3");
    sel8 = 1'b1; checkQuiet("rst_vs_start8");
    tick();
    checkQuiet("rst_vs_start_after");
  endtask

  task automatic test_forward3();
    applyReset();
    sel8 = 1'b0;
    expQ.delete();
    for (int i = 0; i < 12; i++)
      expQ.push_back('{a: fwdTab[i][0], b: fwdTab[i][1], tw: fwdTab[i][2], st: i / 4});
    startXfer(1'b0, 1'b0);
    follow(12, 100, 1'b0);
    checkDone("fwd3");
    tick();
    checkQuiet("fwd3_after");
  endtask

  task automatic test_inverse3();
    applyReset();
    sel8 = 1'b0;
    buildSeq(3, 1'b1);
    startXfer(1'b1, 1'b0);
    follow(expQ.size(), 70, 1'b0);
    checkDone("inv3");
    tick();
    checkQuiet("inv3_after");
  endtask

  task automatic test_backpressure8(input bit inv);
    int base;
    applyReset();
    sel8 = 1'b1;
    buildSeq(8, inv);
    base = hs8;
    startXfer(inv, 1'b0);
    follow(expQ.size(), 60, 1'b0);
    checkDone(inv ? "bp8_inv" : "bp8_fwd");
    tick();
    checkQuiet(inv ? "bp8_inv_after" : "bp8_fwd_after");
    checks++;
    if (hs8 - base != 1024) begin
      errors++;
      $display("FAIL bp8_handshakes got %0d expected 1024", hs8 - base);
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    sel8 = 1'b0;
    buildSeq(3, 1'b0);
    startXfer(1'b0, 1'b0);
    follow(5, 100, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkQuiet("rst_mid");
    tick();
    checkQuiet("rst_mid_nodone");
    startXfer(1'b0, 1'b0);
    follow(expQ.size(), 100, 1'b0);
    checkDone("rst_mid_restart");
  endtask

  task automatic test_busy_ignore();
    applyReset();
    sel8 = 1'b0;
    buildSeq(3, 1'b1);
    startXfer(1'b1, 1'b0);
    follow(expQ.size(), 80, 1'b1);
    checkDone("busy_ignore");
    tick();
    checkQuiet("busy_ignore_after");
  endtask

  task automatic test_back_to_back();
    applyReset();
    sel8 = 1'b0;
    buildSeq(3, 1'b0);
    startXfer(1'b0, 1'b1);
    follow(expQ.size(), 100, 1'b0);
    checkDone("b2b_first");
    // start is still high through the done cycle.
    tick();
    start = 1'b0;
    idx = 0;
    follow(expQ.size(), 100, 1'b0);
    checkDone("b2b_second");
    tick();
    checkQuiet("b2b_after");
  endtask

  initial begin
    sel8 = 1'b0;
    rst = 1'b1; start = 1'b0; inverse = 1'b0; ready = 1'b0;
    test_reset();
    test_forward3();
    test_inverse3();
    test_backpressure8(1'b0);
    test_backpressure8(1'b1);
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ntt_addr_seq.md
NTT_ADDR_SEQ -- requirements
Module: ntt_addr_seq

Interface
REQ-001 SHALL have parameter LOG_N, default 8, meaning log2 of transform length N = 2^LOG_N (LOG_N >= 2).
REQ-002 SHALL have parameter SW, default $clog2(LOG_N), meaning the width of the stage index.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a full transform when idle.
REQ-006 SHALL have port inverse  input  1  mode, sampled with start: 0 = forward Cooley-Tukey, 1 = inverse Gentleman-Sande.
REQ-007 SHALL have port ready  input  1  downstream accepts the current pair.
REQ-008 SHALL have port valid  output  1  addr_a/addr_b/tw_addr/stage hold a pair.
REQ-009 SHALL have port addr_a  output  LOG_N  lower butterfly address.
REQ-010 SHALL have port addr_b  output  LOG_N  upper butterfly address (addr_a + half).
REQ-011 SHALL have port tw_addr  output  LOG_N  twiddle ROM index.
REQ-012 SHALL have port stage  output  SW  current stage, 0..LOG_N-1.
REQ-013 SHALL have port busy  output  1  transform in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last pair is accepted.

Function
REQ-015 SHALL use states IDLE and RUN; IDLE->RUN on start, RUN->IDLE on acceptance of the final pair.
REQ-016 SHALL assert valid and busy in the cycle after start is sampled in IDLE, with stage 0 group 0 k 0.
REQ-017 SHALL advance to the next pair only on valid && ready; outputs SHALL remain stable while valid && !ready.
REQ-018 SHALL emit exactly N/2 pairs per stage and LOG_N stages, i.e. LOG_N*N/2 accepted pairs per transform, with no bubble at stage boundaries.
REQ-019 SHALL, in forward mode, use half = N >> (stage+1).
REQ-020 SHALL, in inverse mode, use half = 1 << stage.
REQ-021 SHALL enumerate pairs with group as the outer loop (0..N/(2*half)-1) and k as the inner loop (0..half-1).
REQ-022 SHALL compute addr_a = group*2*half + k and addr_b = addr_a + half.
REQ-023 SHALL compute tw_addr = N/(2*half) + group in both modes.
REQ-024 SHALL derive all addresses by shifts and counters, using no dividers or multipliers; all arithmetic is modulo 2^LOG_N.
REQ-025 SHALL ignore start while busy and SHALL ignore changes to inverse after it has been sampled.
REQ-026 SHALL pulse done for exactly one cycle, in the cycle after the final handshake, with valid=0 and busy=0 in that same cycle.
REQ-027 SHALL accept a start sampled in the done cycle.
REQ-028 SHALL hold addr_a, addr_b, tw_addr and stage at 0 whenever valid=0.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, go to IDLE with valid=0, busy=0, done=0 and all address, stage and counter registers at 0, including mid-transform.
REQ-030 SHALL give rst priority over start in the same cycle.

Structure
REQ-031 SHALL place the state enum (IDLE, RUN) and the mode enum (FWD, INV) in shared package ntt_pkg.
REQ-032 SHALL be a single module with counters inline; no sub-module is required.

Verification
REQ-033 SHALL cover forward mode, LOG_N=3, ready=1: the accepted pairs are (0,4,1)(1,5,1)(2,6,1)(3,7,1) | (0,2,2)(1,3,2)(4,6,3)(5,7,3) | (0,1,4)(2,3,5)(4,5,6)(6,7,7), given as (addr_a, addr_b, tw_addr); done pulses one cycle after the 12th handshake.
REQ-034 SHALL cover inverse mode, LOG_N=3: stage 0 is (0,1,4)(2,3,5)(4,5,6)(6,7,7); stage 1 is (0,2,2)(1,3,2)(4,6,3)(5,7,3); stage 2 is (0,4,1)..(3,7,1).
REQ-035 SHALL cover random ready backpressure with LOG_N=8: the sequence is identical to the ready=1 run, outputs are stable during stalls, and exactly 1024 handshakes occur.
REQ-036 SHALL cover rst asserted at pair 5 of stage 1: the next cycle shows valid=0 and busy=0 with no done pulse; a new start restarts at (0,4,1) for LOG_N=3.
REQ-037 SHALL cover start pulsed while busy, and the inverse input toggled mid-run: there is no effect on the sequence.
REQ-038 SHALL cover start held high through the done cycle: a second transform begins and valid is high in the cycle after done.
